// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch front end: control-transfer opcodes and fetch FSM states.
package pc_fetch_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_branch_target_gen.sv
// Combinational decode of the instruction in execute into a redirect flag and target address.
module branch_target_gen
  import pc_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_inst,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             cmp_out,
  output logic             redirect,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] b_imm;
  logic [WIDTH-1:0] j_imm;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jal_target;
  logic [WIDTH-1:0] jalr_target;

  assign b_imm = {{(WIDTH-13){ex_inst[31]}}, ex_inst[31], ex_inst[7],
                  ex_inst[30:25], ex_inst[11:8], 1'b0};
  assign j_imm = {{(WIDTH-21){ex_inst[31]}}, ex_inst[31], ex_inst[19:12],
                  ex_inst[20], ex_inst[30:21], 1'b0};

  // Targets wrap modulo 2^WIDTH; JALR clears bit 0 of rs1+imm.
  assign br_target   = ex_pc + b_imm;
  assign jal_target  = ex_pc + j_imm;
  assign jalr_target = alu_out & ~(WIDTH'(1));

  always_comb begin
    redirect = 1'b0;
    target   = br_target;
    case (ex_inst[6:0])
      OP_BRANCH: begin
        redirect = ex_valid & cmp_out;
        target   = br_target;
      end
      OP_JAL: begin
        redirect = ex_valid;
        target   = jal_target;
      end
      OP_JALR: begin
        redirect = ex_valid;
        target   = jalr_target;
      end
      default: begin
        redirect = 1'b0;
        target   = br_target;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: one req/ack fetch at a time, one instruction held
// toward decode, with redirects from execute squashing wrong-path fetches.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_inst,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             cmp_out,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic             misalign_err
);

  fetch_state_e     state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] bus_pc;
  logic [WIDTH-1:0] target;
  logic             discard;

  branch_target_gen #(
    .WIDTH(WIDTH)
  ) u_target_gen (
    .ex_valid(ex_valid),
    .ex_inst (ex_inst),
    .ex_pc   (ex_pc),
    .alu_out (alu_out),
    .cmp_out (cmp_out),
    .redirect(redirect),
    .target  (target)
  );

  // While a squashed request is still outstanding the bus keeps its original address.
  assign imem_req   = (state == ST_REQ);
  assign imem_addr  = discard ? bus_pc : fetch_pc;
  assign inst_valid = (state == ST_HOLD) && !redirect;
  assign pc_plus4   = pc_out + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_REQ;
      fetch_pc     <= RESET_PC;
      bus_pc       <= RESET_PC;
      discard      <= 1'b0;
      misalign_err <= 1'b0;
      inst_out     <= '0;
      pc_out       <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (redirect) begin
            fetch_pc <= target;
            if (target[1]) begin
              misalign_err <= 1'b1;
              discard      <= 1'b0;
              state        <= ST_ERR;
            end else if (imem_ack) begin
              discard <= 1'b0;
            end else begin
              // Remember the in-flight address only on the first squash of this request.
              if (!discard) begin
                bus_pc <= fetch_pc;
              end
              discard <= 1'b1;
            end
          end else if (imem_ack) begin
            if (discard) begin
              discard <= 1'b0;
            end else begin
              inst_out <= imem_rdata;
              pc_out   <= fetch_pc;
              fetch_pc <= fetch_pc + WIDTH'(4);
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            fetch_pc <= target;
            if (target[1]) begin
              misalign_err <= 1'b1;
              state        <= ST_ERR;
            end else begin
              state <= ST_REQ;
            end
          end else if (inst_ready) begin
            state <= ST_REQ;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder, transfer scoreboard, redirect vector table
// and hand-written sequences for squash, backpressure, misalignment and reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_inst = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] alu_out = '0;
  logic        cmp_out = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misalign_err;

  pc_fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_inst     (ex_inst),
    .ex_pc       (ex_pc),
    .alu_out     (alu_out),
    .cmp_out     (cmp_out),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .redirect    (redirect),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        cmp;
    logic        exp_redirect;
    logic [31:0] exp_target;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] ack_log[$];
  vec_t        vecs[10];
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  int          mem_cnt = 0;
  int          wn;
  logic [31:0] exp_hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    sb_q.push_back(e);
  endtask

  // Memory: acks every request a fixed number of cycles after it is first seen.
  always begin
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (rst || !imem_req) begin
      mem_cnt = 0;
    end else if (mem_cnt == 2) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      mem_cnt    = 0;
    end else begin
      mem_cnt++;
    end
  end

  // Scoreboard: every transfer toward decode must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && imem_ack) ack_log.push_back(imem_addr);
    if (!rst && inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_xfer actual pc=0x%08h required=none", pc_out);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("xfer_pc", pc_out, mon_e.pc);
        check_output("xfer_inst", inst_out, mon_e.inst);
        check_output("xfer_pc_plus4", pc_plus4, mon_e.pc + 32'd4);
        accepted++;
      end
    end
  end

  task automatic wait_hold(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_hold_timeout actual=no_inst_valid required=inst_valid");
    end
  endtask

  task automatic accept_one();
    wait_hold(60);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_inst_valid", inst_valid, 1'b0);
    check_output("rst_pc_out", pc_out, 32'h0);
    check_output("rst_inst_out", inst_out, 32'h0);
    check_output("rst_misalign", misalign_err, 1'b0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    ack_log.delete();
  endtask

  task automatic apply_stimulus(input vec_t v);
    ex_valid = v.valid;
    ex_inst  = v.inst;
    ex_pc    = v.pc;
    alu_out  = v.alu;
    cmp_out  = v.cmp;
  endtask

  initial begin
    vecs[0] = '{1'b1, enc_b(13'h0010, 3'd0), 32'h40,   32'h0,   1'b1, 1'b1, 32'h50};
    vecs[1] = '{1'b1, enc_b(13'h1FFC, 3'd1), 32'h40,   32'h0,   1'b1, 1'b1, 32'h3C};
    vecs[2] = '{1'b1, enc_b(13'h0010, 3'd0), 32'h40,   32'h0,   1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, enc_j(21'h000800),     32'h1000, 32'h0,   1'b0, 1'b1, 32'h1800};
    vecs[4] = '{1'b1, enc_j(21'h1FFFFC),     32'h20,   32'h0,   1'b0, 1'b1, 32'h1C};
    vecs[5] = '{1'b1, 32'h0040_80E7,         32'h80,   32'h301, 1'b0, 1'b1, 32'h300};
    vecs[6] = '{1'b0, enc_j(21'h000040),     32'h80,   32'h0,   1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h0020_80B3,         32'h80,   32'h0,   1'b1, 1'b0, 32'h0};
    vecs[8] = '{1'b1, enc_b(13'h1000, 3'd0), 32'h2000, 32'h0,   1'b1, 1'b1, 32'h1000};
    vecs[9] = '{1'b1, enc_j(21'h000100),     32'h0,    32'h0,   1'b0, 1'b1, 32'h100};

    // Straight-line fetch with decode always ready.
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    inst_ready = 1'b1;
    wn = 0;
    while (accepted < 3 && wn < 60) begin
      @(posedge clk); #1;
      wn++;
    end
    inst_ready = 1'b0;
    if (accepted < 3) begin
      checks++;
      failures++;
      $display("[TB] FAIL p1_timeout actual=%0d required=3", accepted);
    end
    check_output("p1_ack_count", 32'(ack_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < ack_log.size()) check_output("p1_ack_addr", ack_log[i], 32'(i * 4));
    end

    // Backpressure: held instruction stays put and no new request goes out.
    push_exp(32'hC);
    wait_hold(60);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_inst_valid", inst_valid, 1'b1);
      check_output("bp_inst_out", inst_out, mem_word(32'hC));
      check_output("bp_pc_out", pc_out, 32'hC);
      check_output("bp_imem_req", imem_req, 1'b0);
    end
    accept_one();

    // Redirect decode table, applied while an instruction is held.
    exp_hold = 32'h10;
    for (int i = 0; i < 10; i++) begin
      wait_hold(60);
      check_output("tbl_hold_pc", pc_out, exp_hold);
      @(posedge clk); #1;
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output("tbl_redirect", redirect, vecs[i].exp_redirect);
      check_output("tbl_inst_valid", inst_valid, !vecs[i].exp_redirect);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      cmp_out  = 1'b0;
      @(negedge clk);
      if (vecs[i].exp_redirect) begin
        check_output("tbl_req", imem_req, 1'b1);
        check_output("tbl_target", imem_addr, vecs[i].exp_target);
        exp_hold = vecs[i].exp_target;
      end else begin
        check_output("tbl_still_hold", inst_valid, 1'b1);
        check_output("tbl_pc_kept", pc_out, exp_hold);
      end
    end

    // Taken BEQ while the fetch of 0x108 is outstanding.
    push_exp(32'h100);
    accept_one();
    push_exp(32'h104);
    accept_one();
    ack_log.delete();
    ex_inst  = enc_b(13'h1FF8, 3'd0);
    ex_pc    = 32'h100;
    cmp_out  = 1'b1;
    ex_valid = 1'b1;
    @(negedge clk);
    check_output("beq_redirect", redirect, 1'b1);
    check_output("beq_addr_before", imem_addr, 32'h108);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    cmp_out  = 1'b0;
    @(negedge clk);
    check_output("beq_addr_held", imem_addr, 32'h108);
    check_output("beq_req_held", imem_req, 1'b1);
    push_exp(32'hF8);
    accept_one();
    check_output("beq_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      check_output("beq_ack0", ack_log[0], 32'h108);
      check_output("beq_ack1", ack_log[1], 32'hF8);
    end

    // Same BEQ not taken: fetch continues sequentially.
    push_exp(32'hFC);
    accept_one();
    push_exp(32'h100);
    accept_one();
    push_exp(32'h104);
    accept_one();
    ex_inst  = enc_b(13'h1FF8, 3'd0);
    ex_pc    = 32'h100;
    cmp_out  = 1'b0;
    ex_valid = 1'b1;
    @(negedge clk);
    check_output("bnt_redirect", redirect, 1'b0);
    check_output("bnt_addr", imem_addr, 32'h108);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    push_exp(32'h108);
    accept_one();
    push_exp(32'h10C);
    accept_one();

    // Misaligned JALR target while holding with decode ready.
    wait_hold(60);
    check_output("jalr_hold_pc", pc_out, 32'h110);
    @(posedge clk); #1;
    ex_inst    = 32'h0000_0067;
    alu_out    = 32'h2003;
    ex_valid   = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check_output("jalr_redirect", redirect, 1'b1);
    check_output("jalr_no_valid", inst_valid, 1'b0);
    @(posedge clk); #1;
    ex_valid   = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    check_output("err_misalign", misalign_err, 1'b1);
    check_output("err_addr", imem_addr, 32'h2002);
    check_output("err_inst_valid", inst_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("err_req_low", imem_req, 1'b0);
      check_output("err_sticky", misalign_err, 1'b1);
    end

    // JAL wrapping past the top of the address space, then reset mid-request.
    do_reset();
    wait_hold(60);
    check_output("wrap_hold_pc", pc_out, 32'h0);
    @(posedge clk); #1;
    ex_inst  = enc_j(21'h000008);
    ex_pc    = 32'hFFFF_FFFC;
    ex_valid = 1'b1;
    @(negedge clk);
    check_output("wrap_redirect", redirect, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check_output("wrap_addr", imem_addr, 32'h4);
    check_output("wrap_req", imem_req, 1'b1);
    do_reset();
    push_exp(32'h0);
    accept_one();
    check_output("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
